// File: rtl/ca_gen_sequencer.sv
// Generation sequencer for the 80-cell CA: paces generations to frame ticks, drives
// seed/feedback select, strobes and row addresses, and owns the rule register.
// Optional define CA_SCROLL_EN: rows wrap and the screen scrolls instead of halting.
module ca_gen_sequencer #(
    parameter int ROWS           = 60,
    parameter int ROW_W          = 7,
    parameter int INIT_RULE      = 30,
    parameter int FRAMES_PER_GEN = 4,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             rule_up,
    input  logic             rule_dn,
    input  logic             restart,
    output logic             seed_sel,
    output logic             gen_load,
    output logic             row_we,
    output logic [ROW_W-1:0] row_w,
    output logic [7:0]       rule,
    output logic [CNT_W-1:0] gen_count,
    output logic             done,
    output logic [ROW_W-1:0] scroll_base
);

    localparam int               FC_W     = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_GEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [7:0]       RULE_RST = 8'(INIT_RULE);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        WAIT,
        STEP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [7:0]       rule_q, rule_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic             seed_sel_q, seed_sel_d;
    logic             gen_load_q, gen_load_d;
    logic             row_we_q, row_we_d;
    logic             done_q, done_d;
    logic             rule_chg;
    logic             reseed_req;
    logic [ROW_W-1:0] row_next;

`ifdef CA_SCROLL_EN
    logic             wrapped_q, wrapped_d;
    logic [ROW_W-1:0] sbase_q, sbase_d;
`endif

    // up and dn together cancel: neither the rule nor the sequence is disturbed
    assign rule_chg   = rule_up ^ rule_dn;
    assign reseed_req = rule_chg | restart;

    always_comb begin
        rule_d = rule_q;
        if (rule_up && !rule_dn) begin
            rule_d = rule_q + 8'd1;
        end else if (rule_dn && !rule_up) begin
            rule_d = rule_q - 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = SEED;
                    fcnt_d  = '0;
                end
            end
            SEED: state_d = WAIT;
            WAIT: begin
                if (frame_tick) begin
                    if (fcnt_q == FC_LAST) begin
                        state_d = STEP;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + FC_W'(1);
                    end
                end
            end
            STEP: begin
`ifdef CA_SCROLL_EN
                state_d = WAIT;
`else
                state_d = (row_q < ROW_LAST) ? WAIT : DONE;
`endif
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        // a rule change or restart pre-empts everything, including a coincident tick
        if (reseed_req) begin
            state_d = IDLE;
        end
    end

    assign row_next = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);

    // outputs are decoded from the next state so that they are registered with it
    always_comb begin
        seed_sel_d = 1'b0;
        gen_load_d = 1'b0;
        row_we_d   = 1'b0;
        done_d     = 1'b0;
        row_d      = row_q;
        gcnt_d     = gcnt_q;
`ifdef CA_SCROLL_EN
        wrapped_d  = wrapped_q;
        sbase_d    = sbase_q;
`endif
        case (state_d)
            SEED: begin
                gen_load_d = 1'b1;
                row_we_d   = 1'b1;
                row_d      = '0;
                gcnt_d     = '0;
`ifdef CA_SCROLL_EN
                wrapped_d  = 1'b0;
                sbase_d    = '0;
`endif
            end
            WAIT: seed_sel_d = 1'b1;
            STEP: begin
                seed_sel_d = 1'b1;
                gen_load_d = 1'b1;
                row_we_d   = 1'b1;
                row_d      = row_next;
                gcnt_d     = (gcnt_q == '1) ? gcnt_q : gcnt_q + CNT_W'(1);
`ifdef CA_SCROLL_EN
                if (row_q == ROW_LAST) begin
                    wrapped_d = 1'b1;
                end
                // once wrapped, the row after the newest one is the oldest on screen
                if (wrapped_q || (row_q == ROW_LAST)) begin
                    sbase_d = (row_next == ROW_LAST) ? '0 : row_next + ROW_W'(1);
                end
`endif
            end
            DONE: begin
                seed_sel_d = 1'b1;
                done_d     = 1'b1;
            end
            default: begin
                seed_sel_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fcnt_q     <= '0;
            row_q      <= '0;
            rule_q     <= RULE_RST;
            gcnt_q     <= '0;
            seed_sel_q <= 1'b0;
            gen_load_q <= 1'b0;
            row_we_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            row_q      <= row_d;
            rule_q     <= rule_d;
            gcnt_q     <= gcnt_d;
            seed_sel_q <= seed_sel_d;
            gen_load_q <= gen_load_d;
            row_we_q   <= row_we_d;
            done_q     <= done_d;
        end
    end

`ifdef CA_SCROLL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrapped_q <= 1'b0;
            sbase_q   <= '0;
        end else begin
            wrapped_q <= wrapped_d;
            sbase_q   <= sbase_d;
        end
    end

    assign scroll_base = sbase_q;
`else
    assign scroll_base = '0;
`endif

    assign seed_sel  = seed_sel_q;
    assign gen_load  = gen_load_q;
    assign row_we    = row_we_q;
    assign row_w     = row_q;
    assign rule      = rule_q;
    assign gen_count = gcnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ca_gen_sequencer.sv
// Randomized bench for ca_gen_sequencer; expected outputs come from a tick-counting
// model of the generation schedule (row = generations mod ROWS, write every FPG ticks).
module tb_ca_gen_sequencer;

    localparam int ROWS           = 60;
    localparam int ROW_W          = 7;
    localparam int INIT_RULE      = 30;
    localparam int FRAMES_PER_GEN = 4;
    localparam int CNT_W          = 16;
    localparam int CMAX           = (1 << CNT_W) - 1;
`ifdef CA_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             frame_tick;
    logic             rule_up;
    logic             rule_dn;
    logic             restart;
    logic             seed_sel;
    logic             gen_load;
    logic             row_we;
    logic [ROW_W-1:0] row_w;
    logic [7:0]       rule;
    logic [CNT_W-1:0] gen_count;
    logic             done;
    logic [ROW_W-1:0] scroll_base;

    ca_gen_sequencer #(
        .ROWS          (ROWS),
        .ROW_W         (ROW_W),
        .INIT_RULE     (INIT_RULE),
        .FRAMES_PER_GEN(FRAMES_PER_GEN),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .rule_up    (rule_up),
        .rule_dn    (rule_dn),
        .restart    (restart),
        .seed_sel   (seed_sel),
        .gen_load   (gen_load),
        .row_we     (row_we),
        .row_w      (row_w),
        .rule       (rule),
        .gen_count  (gen_count),
        .done       (done),
        .scroll_base(scroll_base)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_bad;

    // model: phase 0 = waiting for a tick to seed, 1 = generating, 2 = screen full
    int m_phase;
    int m_rule;
    int m_ticks;
    int m_gens;
    int m_row;
    int m_sbase;
    bit m_we;
    bit m_seedstrobe;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_phase      = 0;
        m_rule       = INIT_RULE;
        m_ticks      = 0;
        m_gens       = 0;
        m_row        = 0;
        m_sbase      = 0;
        m_we         = 1'b0;
        m_seedstrobe = 1'b0;
    endtask

    task automatic model_edge(input bit t, input bit u, input bit d, input bit r);
        m_we         = 1'b0;
        m_seedstrobe = 1'b0;
        if (u && !d) m_rule = (m_rule + 1) % 256;
        if (d && !u) m_rule = (m_rule + 255) % 256;
        if ((u != d) || r) begin
            m_phase = 0;
        end else if (t) begin
            if (m_phase == 0) begin
                m_phase      = 1;
                m_ticks      = 0;
                m_gens       = 0;
                m_row        = 0;
                m_sbase      = 0;
                m_we         = 1'b1;
                m_seedstrobe = 1'b1;
            end else if (m_phase == 1) begin
                m_ticks++;
                if (m_ticks % FRAMES_PER_GEN == 0) begin
                    m_gens++;
                    m_row = m_gens % ROWS;
                    m_we  = 1'b1;
                    if (SCROLL) begin
                        if (m_gens >= ROWS) m_sbase = (m_row + 1) % ROWS;
                    end else if (m_gens == ROWS - 1) begin
                        m_phase = 2;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check_val("row_we", row_we, m_we);
        check_val("gen_load", gen_load, m_we);
        check_val("seed_sel", seed_sel, (m_phase != 0) && !m_seedstrobe);
        check_val("row_w", row_w, m_row);
        check_val("rule", rule, m_rule);
        check_val("gen_count", gen_count, (m_gens > CMAX) ? CMAX : m_gens);
        check_val("done", done, (m_phase == 2) && !m_we);
        check_val("scroll_base", scroll_base, m_sbase);
    endtask

    task automatic step(input bit t, input bit u, input bit d, input bit r);
        @(negedge clk);
        frame_tick = t;
        rule_up    = u;
        rule_dn    = d;
        restart    = r;
        @(posedge clk);
        model_edge(t, u, d, r);
        #1;
        check_all();
    endtask

    task automatic tick_run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(1, 4)) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit pt;
        bit found;
        n_total    = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        rule_up    = 1'b0;
        rule_dn    = 1'b0;
        restart    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // seed and first generations, then simultaneous up/dn mid-WAIT
        tick_run(12);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        // fill the screen (245 ticks total) and tick past the end
        tick_run(233);

        // walk the rule down to 0, then 0 - 1 mid-WAIT
        repeat (30) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick_run(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tick_run(5);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tick_run(3);
        // rule_up coincident with a tick: the tick is discarded
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tick_run(6);
        // rule change landing on a strobe cycle, then restart
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tick_run(6);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tick_run(4);

        pt = 1'b0;
        for (int i = 0; i < 800; i++) begin
            bit t, u, d, r;
            t = !pt && ($urandom_range(0, 2) == 0);
            u = ($urandom_range(0, 99) == 0);
            d = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 149) == 0);
            step(t, u, d, r);
            pt = t;
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // reset asserted in the middle of a STEP strobe
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (m_we && !m_seedstrobe) found = 1'b1;
            else step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_val("midstep_found", found, 1'b1);
        frame_tick = 1'b0;
        rule_up    = 1'b0;
        rule_dn    = 1'b0;
        restart    = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_val("rst_row_we", row_we, 1'b0);
        check_val("rst_gen_load", gen_load, 1'b0);
        check_val("rst_row_w", row_w, 0);
        check_val("rst_rule", rule, INIT_RULE);
        check_val("rst_gen_count", gen_count, 0);
        check_val("rst_seed_sel", seed_sel, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick_run(6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ca_gen_sequencer.md
# ca_gen_sequencer

Generation sequencer for the 80-cell cellular-automaton datapath. It paces generations to the VGA frame rate, selects between seed and feedback at the automaton input, strobes the generation register, and issues row-write addresses to the image buffer. It also owns the live rule register, which the board buttons step up and down. It replaces the free-running prescaler, init and row-counter glue, and sits on the pixel-clock domain between the VGA sync block and the automaton and image store.

## Interface
Parameters:
- ROWS, 60, number of image rows, one generation per row
- ROW_W, 7, width of row address
- INIT_RULE, 30, rule value loaded at reset
- FRAMES_PER_GEN, 4, frame ticks between generations; must be ≥1
- CNT_W, 16, generation counter width

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, at vblank start
- rule_up  in  1  one-cycle pulse (debounced upstream): rule + 1
- rule_dn  in  1  one-cycle pulse: rule − 1
- restart  in  1  one-cycle pulse: reseed from row 0
- seed_sel  out  1  0 = automaton input is SEED; 1 = generation register feedback
- gen_load  out  1  one-cycle strobe: generation register captures automaton output
- row_we  out  1  one-cycle strobe: image store writes automaton input word at row_w
- row_w  out  ROW_W  row address for the current write
- rule  out  8  current rule, fed to automaton
- gen_count  out  CNT_W  STEP writes since last seed, saturating
- done  out  1  screen full, stepping halted (always 0 with scroll enabled)
- scroll_base  out  ROW_W  display row that maps to screen top (0 without scroll)

## Operation
- FSM states: IDLE, SEED, WAIT, STEP, DONE.
- IDLE: all strobes low. On frame_tick, go to SEED.
- SEED, one cycle: seed_sel=0, row_we=1, gen_load=1, row_w=0, gen_count←0, frame counter←0. Then go to WAIT.
- WAIT: seed_sel=1. Count frame_ticks. On the FRAMES_PER_GEN-th tick, go to STEP.
- STEP, one cycle: seed_sel=1, row_we=1, gen_load=1, row_w=previous+1, gen_count+1 (saturates at 2^CNT_W−1). Then:
  - if row_w < ROWS−1, go to WAIT;
  - otherwise go to DONE (no scroll) or WAIT (scroll).
- DONE: done=1, seed_sel=1, no strobes. frame_tick is ignored. Leaves only on a rule change or restart.
- Rule arithmetic: modulo 256. 255+1=0; 0−1=255.
- rule_up and rule_dn in the same cycle: no change and no reseed.
- Effective rule change (up xor dn), or restart: go to IDLE next cycle and clear done. Reseed happens at the next frame_tick.
- Rule change or restart in the same cycle as frame_tick: the change wins and the tick is discarded.
- Rule change during a SEED or STEP cycle: that cycle's strobes still complete, then the FSM goes to IDLE.
- Reset mid-operation: everything returns to reset values immediately; no partial strobe is extended.

## Timing
- All outputs are registered (Moore).
- Strobes assert on the cycle after the clk edge that samples the triggering frame_tick, and last exactly one cycle.
- row_w and seed_sel are valid in the same cycle as row_we and gen_load.
- rule updates one cycle after rule_up or rule_dn.
- Generation period is FRAMES_PER_GEN frames. Row k (k≥1) is written FRAMES_PER_GEN·k+1 ticks after leaving IDLE.
- Reset values:
  - state IDLE
  - seed_sel 0, gen_load 0, row_we 0
  - row_w 0
  - rule INIT_RULE
  - gen_count 0
  - done 0
  - scroll_base 0

## Configuration
- CA_SCROLL_EN defined:
  - After row ROWS−1, STEP wraps row_w to 0 and stepping continues indefinitely.
  - scroll_base updates with each wrapped STEP to (row_w+1) mod ROWS, so the oldest row displays at the top.
  - done stays 0.
- CA_SCROLL_EN undefined: the FSM halts in DONE after row ROWS−1, and scroll_base is tied to 0.

## Test plan
- Reset release, FRAMES_PER_GEN=4, frame_tick every 100 cycles → SEED strobes after tick 1 (row_w=0, seed_sel=0). Row 1 STEP after tick 5; row 2 after tick 9. rule=30.
- No scroll, 237 ticks → row_w reaches 59 after tick 237, done=1, gen_count=59. Further ticks produce no strobes.
- rule_dn pulse at rule=0, mid-WAIT → rule=255, state IDLE. The next tick reseeds row 0 and gen_count=0.
- rule_up and rule_dn together → rule unchanged, stepping uninterrupted. rule_up coincident with frame_tick → no STEP; reseed on the following tick.
- rst_n low during a STEP cycle → row_we and gen_load drop immediately, row_w=0, rule=30.
- CA_SCROLL_EN, 241 ticks → the write after row 59 goes to row_w=0 with seed_sel=1, scroll_base=1, done=0.
